// File: rtl/iobus_uart_tx.sv
// iobus_uart_tx: IOBUS-mapped UART transmitter with DATA/STATUS/CTRL registers, byte FIFO and serialiser.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module iobus_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
  parameter int          BAUD_DIV   = 868,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        TX,
  output logic        INTR
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_TOP = BW'(BAUD_DIV - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
  logic parity;
`endif
  logic [31:0] offset;
  logic inWin, dataWr, ctrlWr, statusRd, flush;
  logic push, pop, empty, full, busy, baudDone;
  logic overflow, irqEn, unusedOut;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic [7:0] cntByte, shift;
  logic [2:0] state, bitIdx;
  logic [BW-1:0] baudCnt;
  // base is word aligned, so the offset keeps address bits [1:0] and they fall out of the decode
  assign offset    = IOBUS_ADDR - BASE_ADDR;
  assign inWin     = offset < 32'd12;
  assign dataWr    = IOBUS_WR & inWin & (offset[3:2] == 2'd0);
  assign ctrlWr    = IOBUS_WR & inWin & (offset[3:2] == 2'd2);
  assign statusRd  = inWin & (offset[3:2] == 2'd1);
  assign flush     = ctrlWr & IOBUS_OUT[1];
  assign unusedOut = ^IOBUS_OUT[31:8];
  assign empty    = count == '0;
  assign full     = count == CW'(FIFO_DEPTH);
  assign busy     = state != IDLE;
  assign baudDone = baudCnt == '0;
  assign push     = dataWr & ~full;
  assign pop      = ~empty & ~flush & ((state == IDLE) | ((state == STOP) & baudDone));
  assign cntByte  = 8'(count);
  assign IOBUS_IN = statusRd ? {16'b0, cntByte, 3'b0, irqEn, overflow, full, empty, busy} : 32'b0;
  assign INTR     = irqEn & empty & ~busy;
  assign TX = (state == START) ? 1'b0 :
              (state == DATA)  ? shift[0] :
`ifdef UART_TX_PARITY_EN
              (state == PARITY) ? parity :
`endif
              1'b1;
  always_ff @(posedge CLK)
    if (push) mem[wrPtr] <= IOBUS_OUT[7:0];
  always_ff @(posedge CLK) begin
    if (RST) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      irqEn    <= 1'b0;
    end else begin
      if (flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
        count <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + 1'b1;
        if (pop) rdPtr <= rdPtr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
      if (dataWr & full) overflow <= 1'b1;
      else if (ctrlWr & IOBUS_OUT[2]) overflow <= 1'b0;
      if (ctrlWr) irqEn <= IOBUS_OUT[0];
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      baudCnt <= '0;
      bitIdx  <= '0;
      shift   <= '0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      if (busy) baudCnt <= baudDone ? BAUD_TOP : baudCnt - 1'b1;
      else if (pop) baudCnt <= BAUD_TOP;
      // both IDLE and the last STOP cycle load the next byte, so frames run gap-free
      if (pop) shift <= mem[rdPtr];
      else if ((state == DATA) & baudDone) shift <= {1'b0, shift[7:1]};
`ifdef UART_TX_PARITY_EN
      if (pop) parity <= ^mem[rdPtr];
`endif
      if ((state == DATA) & baudDone) bitIdx <= bitIdx + 1'b1;
      case (state)
        IDLE:  if (pop) state <= START;
        START: if (baudDone) state <= DATA;
`ifdef UART_TX_PARITY_EN
        DATA:   if (baudDone && bitIdx == 3'd7) state <= PARITY;
        PARITY: if (baudDone) state <= STOP;
`else
        DATA:  if (baudDone && bitIdx == 3'd7) state <= STOP;
`endif
        STOP:  if (baudDone) state <= pop ? START : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
